// File: rtl/fpu_mul_round.sv
// fpu_mul_round: normalize + round-to-nearest-even stage for a binary32
// multiplier. Takes the raw 48-bit significand product, the biased exponent
// sum and special-case flags. Produces a packed single-precision result after
// two EN-qualified pipeline stages.
//
// Ports
//   CLK, RESET (async, active-high), EN (advance enable)
//   IN_VALID, IN_SIGN, IN_EXP[9:0] (signed ea+eb-127), IN_MANT[47:0]
//   IN_NAN, IN_INF, IN_ZERO        special-case flags, priority NAN>INF>ZERO
//   OUT_VALID, Z[31:0], OUT_OVF, OUT_UNF, OUT_INEXACT
//
// Configuration macro: FPU_ROUND_SUBNORM_EN
//   defined   - tiny results are denormalized and rounded (gradual underflow)
//   undefined - tiny results flush to signed zero with UNF and INEXACT set
module fpu_mul_round (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        IN_VALID,
  input  logic        IN_SIGN,
  input  logic [9:0]  IN_EXP,
  input  logic [47:0] IN_MANT,
  input  logic        IN_NAN,
  input  logic        IN_INF,
  input  logic        IN_ZERO,
  output logic        OUT_VALID,
  output logic [31:0] Z,
  output logic        OUT_OVF,
  output logic        OUT_UNF,
  output logic        OUT_INEXACT
);

  // Round to nearest, ties to even; bit 24 of the result is the carry-out.
  function automatic logic [24:0] round_rne(input logic [23:0] sig,
                                            input logic grd,
                                            input logic stk);
    logic rup;
    rup = grd & (stk | sig[0]);
    return {1'b0, sig} + {24'd0, rup};
  endfunction

`ifdef FPU_ROUND_SUBNORM_EN
  // Right-shift {sig,guard} by sh; everything shifted below the new guard
  // position is folded into sticky. Returns {sig, guard, sticky}.
  function automatic logic [25:0] denorm_shift(input logic [23:0] sig,
                                               input logic grd,
                                               input logic stk,
                                               input logic [5:0] sh);
    logic [50:0] v;
    v = {sig, grd, 26'd0} >> sh;
    return {v[50:27], v[26], (|v[25:0]) | stk};
  endfunction
`endif

  logic signed [10:0] w_e_p0;
  logic [23:0]        w_sig_p0;
  logic               w_grd_p0;
  logic               w_stk_p0;
  logic               w_tiny_p0;
  logic [23:0]        w_sig_n_p0;
  logic               w_grd_n_p0;
  logic               w_stk_n_p0;

  logic               r_vld_p1, r_sign_p1, r_nan_p1, r_inf_p1, r_zero_p1;
  logic               r_tiny_p1, r_grd_p1, r_stk_p1;
  logic signed [10:0] r_exp_p1;
  logic [23:0]        r_sig_p1;

  logic               r_vld_p2, r_ovf_p2, r_unf_p2, r_inex_p2;
  logic [31:0]        r_z_p2;

  // ---- stage 1: normalize the product to [1,2) ----
  always_comb begin
    if (IN_MANT[47]) begin
      w_e_p0   = $signed({IN_EXP[9], IN_EXP}) + 11'sd1;
      w_sig_p0 = IN_MANT[47:24];
      w_grd_p0 = IN_MANT[23];
      w_stk_p0 = |IN_MANT[22:0];
    end else begin
      w_e_p0   = $signed({IN_EXP[9], IN_EXP});
      w_sig_p0 = IN_MANT[46:23];
      w_grd_p0 = IN_MANT[22];
      w_stk_p0 = |IN_MANT[21:0];
    end
    w_tiny_p0 = (w_e_p0 <= 11'sd0);
  end

`ifdef FPU_ROUND_SUBNORM_EN
  logic [5:0] w_sh_p0;
  always_comb begin
    // Shift by 1-e; beyond 26 every significand bit already lands in sticky.
    w_sh_p0 = 6'd0;
    if (w_tiny_p0)
      w_sh_p0 = (w_e_p0 < -11'sd25) ? 6'd26 : 6'(11'sd1 - w_e_p0);
    {w_sig_n_p0, w_grd_n_p0, w_stk_n_p0} =
      denorm_shift(w_sig_p0, w_grd_p0, w_stk_p0, w_sh_p0);
  end
`else
  always_comb begin
    w_sig_n_p0 = w_sig_p0;
    w_grd_n_p0 = w_grd_p0;
    w_stk_n_p0 = w_stk_p0;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vld_p1  <= 1'b0;
      r_sign_p1 <= 1'b0;
      r_nan_p1  <= 1'b0;
      r_inf_p1  <= 1'b0;
      r_zero_p1 <= 1'b0;
      r_tiny_p1 <= 1'b0;
      r_grd_p1  <= 1'b0;
      r_stk_p1  <= 1'b0;
      r_exp_p1  <= '0;
      r_sig_p1  <= '0;
    end else if (EN) begin
      r_vld_p1  <= IN_VALID;
      r_sign_p1 <= IN_SIGN;
      r_nan_p1  <= IN_NAN;
      r_inf_p1  <= IN_INF;
      r_zero_p1 <= IN_ZERO;
      r_tiny_p1 <= w_tiny_p0;
      r_grd_p1  <= w_grd_n_p0;
      r_stk_p1  <= w_stk_n_p0;
      r_exp_p1  <= w_e_p0;
      r_sig_p1  <= w_sig_n_p0;
    end
  end

  // ---- stage 2: round, overflow / underflow, specials ----
  logic [24:0]        w_sum_p1;
  logic signed [10:0] w_exp_fin_p1;
  logic [22:0]        w_frac_p1;
  logic [31:0]        w_z_p1;
  logic               w_ovf_p1, w_unf_p1, w_inex_p1;

  always_comb begin
    w_sum_p1     = round_rne(r_sig_p1, r_grd_p1, r_stk_p1);
    // Carry-out means the significand rolled over to 2.0 -> 1.0, exponent+1.
    w_exp_fin_p1 = r_exp_p1 + $signed({10'd0, w_sum_p1[24]});
    w_frac_p1    = w_sum_p1[24] ? w_sum_p1[23:1] : w_sum_p1[22:0];

    w_z_p1    = {r_sign_p1, w_exp_fin_p1[7:0], w_frac_p1};
    w_ovf_p1  = 1'b0;
    w_unf_p1  = 1'b0;
    w_inex_p1 = r_grd_p1 | r_stk_p1;

    if (r_nan_p1) begin
      w_z_p1    = 32'h7FC0_0000;
      w_inex_p1 = 1'b0;
    end else if (r_inf_p1) begin
      w_z_p1    = {r_sign_p1, 8'hFF, 23'd0};
      w_inex_p1 = 1'b0;
    end else if (r_zero_p1) begin
      w_z_p1    = {r_sign_p1, 31'd0};
      w_inex_p1 = 1'b0;
    end else if (r_tiny_p1) begin
`ifdef FPU_ROUND_SUBNORM_EN
      // A carry into the hidden bit turns the subnormal into min-normal.
      w_z_p1   = {r_sign_p1, 7'd0, w_sum_p1[23], w_sum_p1[22:0]};
      w_unf_p1 = w_inex_p1;
`else
      w_z_p1    = {r_sign_p1, 31'd0};
      w_unf_p1  = 1'b1;
      w_inex_p1 = 1'b1;
`endif
    end else if (w_exp_fin_p1 >= 11'sd255) begin
      w_z_p1    = {r_sign_p1, 8'hFF, 23'd0};
      w_ovf_p1  = 1'b1;
      w_inex_p1 = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vld_p2  <= 1'b0;
      r_z_p2    <= '0;
      r_ovf_p2  <= 1'b0;
      r_unf_p2  <= 1'b0;
      r_inex_p2 <= 1'b0;
    end else if (EN) begin
      r_vld_p2  <= r_vld_p1;
      r_z_p2    <= w_z_p1;
      r_ovf_p2  <= w_ovf_p1;
      r_unf_p2  <= w_unf_p1;
      r_inex_p2 <= w_inex_p1;
    end
  end

  assign OUT_VALID   = r_vld_p2;
  assign Z           = r_z_p2;
  assign OUT_OVF     = r_ovf_p2;
  assign OUT_UNF     = r_unf_p2;
  assign OUT_INEXACT = r_inex_p2;

endmodule

// File: doc/fpu_mul_round.md
# fpu_mul_round

Normalization and rounding stage that sits directly downstream of the `fpu_mul` significand array. It converts the raw 48-bit significand product, the pre-biased exponent sum and the special-case flags into an IEEE-754 single-precision result `Z`. The block is a two-stage pipeline that stalls on `EN` and tracks occupancy with a valid bit.

## Interface
Parameters: none. Format is fixed at binary32.

- `CLK` in 1: rising-edge clock.
- `RESET` in 1: asynchronous, active-high reset.
- `EN` in 1: pipeline advance enable. When 0, every register holds.
- `IN_VALID` in 1: input beat is valid.
- `IN_SIGN` in 1: result sign, `sa ^ sb`.
- `IN_EXP` in 10: signed two's-complement value `ea + eb - 127`, for a product in [1,2).
- `IN_MANT` in 48: product of two 24-bit significands (hidden bit included).
- `IN_NAN` in 1: result is NaN. Upstream already maps inf*0 to this flag.
- `IN_INF` in 1: result is infinity.
- `IN_ZERO` in 1: result is zero.
- `OUT_VALID` out 1: `Z` and the flags are valid.
- `Z` out 32: packed single-precision result.
- `OUT_OVF` out 1: overflow flag.
- `OUT_UNF` out 1: underflow flag.
- `OUT_INEXACT` out 1: inexact flag.

## Operation
**Stage 1: normalize**, registered on `CLK` when `EN` is 1.
- If `IN_MANT[47]=1`:
  - exponent is `e = IN_EXP + 1`;
  - significand is `IN_MANT[47:24]`;
  - guard is `IN_MANT[23]`;
  - sticky is `|IN_MANT[22:0]`.
- Otherwise:
  - exponent is `e = IN_EXP`;
  - significand is `IN_MANT[46:23]`;
  - guard is `IN_MANT[22]`;
  - sticky is `|IN_MANT[21:0]`.
- Tiny case (`e <= 0`) depends on the macro; see Configuration.
- Special-case flags and the sign pass through this stage unchanged.

**Stage 2: round to nearest, ties to even.**
- `round_up = guard & (sticky | lsb)`.
- Compute a 25-bit sum `sig + round_up`.
  - If the sum carries out, the significand becomes 1.0 and the exponent increments.
  - For a subnormal, a carry into the hidden bit makes the result min-normal (exponent field 1).
- Overflow: if the final exponent is ≥ 255, `Z = {sign, 8'hFF, 23'h0}` with `OUT_OVF=1` and `OUT_INEXACT=1`.
- Normal result: `Z = {sign, e[7:0], frac}` and `OUT_INEXACT = guard | sticky`.
- Specials, in priority order NAN > INF > ZERO:
  - NAN: `Z = 32'h7FC00000`.
  - INF: `Z = {sign, 8'hFF, 23'h0}`.
  - ZERO: `Z = {sign, 31'h0}`.
  - All three clear every flag and ignore `IN_EXP` and `IN_MANT`.

**Valid tracking**
- `IN_VALID` travels with the data.
- Data registers may load on invalid beats. `Z` content is don't-care while `OUT_VALID=0`.

## Timing
- Latency is 2 `EN`-high edges from input to output. Throughput is 1 result per cycle.
- `EN=0` freezes both stages, including `OUT_VALID`. The input is ignored that cycle.
- `RESET` clears every register asynchronously:
  - `OUT_VALID=0`, `Z=0`;
  - `OUT_OVF=0`, `OUT_UNF=0`, `OUT_INEXACT=0`.
  - In-flight beats are discarded, with no partial output.
- After `RESET` falls, the first valid output appears 2 `EN` edges after the first accepted `IN_VALID`.
- With `EN=1` and `IN_VALID=1` held every cycle, back-to-back beats stay in order with no bubbles.

## Configuration
Macro `FPU_ROUND_SUBNORM_EN`:
- **Defined**: when `e <= 0`, stage 1 right-shifts the 24-bit significand by `1-e`, saturating at 26.
  - Shifted-out bits fold into guard and sticky. The exponent field is 0.
  - `OUT_UNF = tiny & inexact`.
- **Undefined (default)**: when `e <= 0`, the result is flushed to `{sign, 31'h0}` with `OUT_UNF=1` and `OUT_INEXACT=1`. No rounding is applied.

## Test plan
- 2.0×2.0 (`IN_EXP=129`, `IN_MANT=48'h400000000000`) → `Z=32'h40800000` two edges later, all flags 0.
- 1.5×1.5 (`IN_EXP=127`, `IN_MANT=48'h900000000000`) → `Z=32'h40100000`, normalized via bit 47.
- Tie, even LSB (`IN_EXP=127`, `IN_MANT=48'h400000400000`) → `Z=32'h3F800000`, `OUT_INEXACT=1`.
- Tie, odd LSB (`IN_EXP=127`, `IN_MANT=48'h400000C00000`) → `Z=32'h3F800002`, `OUT_INEXACT=1`.
- Rounding carry (`IN_EXP=127`, `IN_MANT=48'h7FFFFFC00000`) → `Z=32'h40000000`.
- Overflow (`IN_SIGN=1`, `IN_EXP=255`, `IN_MANT=48'h400000000000`) → `Z=32'hFF800000`, `OUT_OVF=1`.
- Tiny input (`IN_EXP=0`, `IN_MANT=48'h400000000000`):
  - macro undefined → `Z=0`, `OUT_UNF=1`;
  - macro defined → `Z=32'h00400000`, `OUT_UNF=0`.
- Specials:
  - `IN_NAN=1` and `IN_INF=1` together → `Z=32'h7FC00000`.
  - `IN_ZERO=1` with `IN_SIGN=1` → `Z=32'h80000000`.
- Three back-to-back beats with `EN` low for 3 cycles mid-stream → outputs arrive in order, held stable during the stall.
- `RESET` asserted with 2 beats in flight → `OUT_VALID=0` and `Z=0` immediately; neither beat appears afterwards.
